// File: rtl/stopwatch_counter.sv
// BCD MM:SS stopwatch core with run/pause and per-field adjust mode.
// Optional rollover pulse on wrap is enabled by defining STOPWATCH_WRAP_PULSE_EN.
module stopwatch_counter #(
    parameter int MAX_MINUTES = 59,
    parameter int SECONDS_MAX = 59
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       tick_1hz,
    input  logic       tick_2hz,
    input  logic       pause,
    input  logic       adj,
    input  logic       sel,
    output logic [3:0] minutes_1,
    output logic [3:0] minutes_0,
    output logic [3:0] seconds_1,
    output logic [3:0] seconds_0,
    output logic       paused,
    output logic       wrap
);

    localparam logic [3:0] MIN_MAX_TENS = 4'(MAX_MINUTES / 10);
    localparam logic [3:0] MIN_MAX_ONES = 4'(MAX_MINUTES % 10);
    localparam logic [3:0] SEC_MAX_TENS = 4'(SECONDS_MAX / 10);
    localparam logic [3:0] SEC_MAX_ONES = 4'(SECONDS_MAX % 10);

    typedef enum logic {
        RUN    = 1'b0,
        PAUSED = 1'b1
    } run_state_t;

    run_state_t state, state_next;

    logic [3:0] min_tens, min_ones, sec_tens, sec_ones;
    logic [3:0] min_tens_next, min_ones_next, sec_tens_next, sec_ones_next;
    logic       sec_inc, min_inc, sec_carry, sec_at_max, min_at_max;

    always_comb begin
        state_next = state;
        if (pause) begin
            state_next = (state == RUN) ? PAUSED : RUN;
        end
    end

    // Ticks are gated by the pre-toggle state; the carry into minutes exists only in normal mode.
    always_comb begin
        sec_at_max = (sec_tens == SEC_MAX_TENS) && (sec_ones == SEC_MAX_ONES);
        min_at_max = (min_tens == MIN_MAX_TENS) && (min_ones == MIN_MAX_ONES);
        sec_inc    = adj ? (tick_2hz && sel) : (tick_1hz && (state == RUN));
        sec_carry  = !adj && sec_inc && sec_at_max;
        min_inc    = (adj && tick_2hz && !sel) || sec_carry;

        sec_tens_next = sec_tens;
        sec_ones_next = sec_ones;
        if (sec_inc) begin
            if (sec_at_max) begin
                sec_tens_next = '0;
                sec_ones_next = '0;
            end else if (sec_ones == 4'd9) begin
                sec_tens_next = sec_tens + 4'd1;
                sec_ones_next = '0;
            end else begin
                sec_ones_next = sec_ones + 4'd1;
            end
        end

        min_tens_next = min_tens;
        min_ones_next = min_ones;
        if (min_inc) begin
            if (min_at_max) begin
                min_tens_next = '0;
                min_ones_next = '0;
            end else if (min_ones == 4'd9) begin
                min_tens_next = min_tens + 4'd1;
                min_ones_next = '0;
            end else begin
                min_ones_next = min_ones + 4'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= RUN;
            min_tens <= '0;
            min_ones <= '0;
            sec_tens <= '0;
            sec_ones <= '0;
        end else begin
            state    <= state_next;
            min_tens <= min_tens_next;
            min_ones <= min_ones_next;
            sec_tens <= sec_tens_next;
            sec_ones <= sec_ones_next;
        end
    end

`ifdef STOPWATCH_WRAP_PULSE_EN
    logic rollover;
    logic wrap_q;

    assign rollover = sec_carry && min_at_max;

    always_ff @(posedge clk) begin
        if (rst) begin
            wrap_q <= 1'b0;
        end else begin
            wrap_q <= rollover;
        end
    end

    assign wrap = wrap_q;
`else
    assign wrap = 1'b0;
`endif

    assign minutes_1 = min_tens;
    assign minutes_0 = min_ones;
    assign seconds_1 = sec_tens;
    assign seconds_0 = sec_ones;
    assign paused    = (state == PAUSED);

endmodule
